// File: rtl/otter_branch_predictor_if.sv
// Fetch-side lookup and EX-side resolve signals shared between the OTTER pipeline
// and its branch predictor.
interface otter_branch_predictor_if #(
  parameter int STAT_W = 32
);
  logic              STALL;
  logic [31:0]       IF_PC;
  logic              PRED_HIT;
  logic              PRED_TAKEN;
  logic [31:0]       PRED_TARGET;
  logic              UPD_VALID;
  logic [31:0]       UPD_PC;
  logic              UPD_IS_COND;
  logic              UPD_TAKEN;
  logic [31:0]       UPD_TARGET;
  logic              UPD_PRED_TAKEN;
  logic [31:0]       UPD_PRED_TARGET;
  logic              MISPREDICT;
  logic [31:0]       REDIRECT_PC;
  logic [STAT_W-1:0] LOOKUP_CNT;
  logic [STAT_W-1:0] MISPRED_CNT;

  modport master (
    output STALL, IF_PC, UPD_VALID, UPD_PC, UPD_IS_COND, UPD_TAKEN, UPD_TARGET,
           UPD_PRED_TAKEN, UPD_PRED_TARGET,
    input  PRED_HIT, PRED_TAKEN, PRED_TARGET, MISPREDICT, REDIRECT_PC,
           LOOKUP_CNT, MISPRED_CNT
  );

  modport slave (
    input  STALL, IF_PC, UPD_VALID, UPD_PC, UPD_IS_COND, UPD_TAKEN, UPD_TARGET,
           UPD_PRED_TAKEN, UPD_PRED_TARGET,
    output PRED_HIT, PRED_TAKEN, PRED_TARGET, MISPREDICT, REDIRECT_PC,
           LOOKUP_CNT, MISPRED_CNT
  );
endinterface

// File: rtl/otter_branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters for the
// pipelined OTTER: looked up from IF, trained and checked for mispredicts in EX.
module otter_branch_predictor #(
  parameter int ENTRIES      = 16,
  parameter int COUNTER_BITS = 2,
  parameter int STAT_W       = 32
) (
  input logic                      CLK,
  input logic                      RST,
  otter_branch_predictor_if.slave  bp
);
  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDXW;
  localparam logic [COUNTER_BITS-1:0] CTR_MAX  = {COUNTER_BITS{1'b1}};
  localparam logic [COUNTER_BITS-1:0] CTR_MIN  = {COUNTER_BITS{1'b0}};
  localparam logic [COUNTER_BITS-1:0] CTR_WEAK = COUNTER_BITS'(1'b1) << (COUNTER_BITS - 1);

  logic                    valid_r   [ENTRIES];
  logic [TAGW-1:0]         tag_r     [ENTRIES];
  logic [31:0]             target_r  [ENTRIES];
  logic                    is_cond_r [ENTRIES];
  logic [COUNTER_BITS-1:0] ctr_r     [ENTRIES];
  logic [STAT_W-1:0]       lookup_cnt_r;
  logic [STAT_W-1:0]       mispred_cnt_r;

  logic [IDXW-1:0] if_idx_s;
  logic [IDXW-1:0] upd_idx_s;
  logic [TAGW-1:0] if_tag_s;
  logic [TAGW-1:0] upd_tag_s;
  logic            pred_hit_s;
  logic            pred_taken_s;
  logic            upd_hit_s;
  logic            mispredict_s;

  function automatic logic [COUNTER_BITS-1:0] ctr_step(
    input logic [COUNTER_BITS-1:0] ctr,
    input logic                    up
  );
    logic [COUNTER_BITS-1:0] nxt;
    nxt = ctr;
    if (up) begin
      if (ctr != CTR_MAX) nxt = ctr + COUNTER_BITS'(1'b1);
      else                nxt = ctr;
    end else begin
      if (ctr != CTR_MIN) nxt = ctr - COUNTER_BITS'(1'b1);
      else                nxt = ctr;
    end
    return nxt;
  endfunction

  assign if_idx_s  = bp.IF_PC[IDXW+1:2];
  assign if_tag_s  = bp.IF_PC[31:IDXW+2];
  assign upd_idx_s = bp.UPD_PC[IDXW+1:2];
  assign upd_tag_s = bp.UPD_PC[31:IDXW+2];

  // Fetch lookup; forced to a miss while reset is asserted so stale entries never leak
  always_comb begin
    pred_hit_s = 1'b0;
    if (!RST && valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s)) pred_hit_s = 1'b1;
    else                                                             pred_hit_s = 1'b0;
  end

  assign pred_taken_s = pred_hit_s & (~is_cond_r[if_idx_s] | ctr_r[if_idx_s][COUNTER_BITS-1]);
  assign upd_hit_s    = valid_r[upd_idx_s] & (tag_r[upd_idx_s] == upd_tag_s);
  assign mispredict_s = bp.UPD_VALID &
                        ((bp.UPD_TAKEN != bp.UPD_PRED_TAKEN) |
                         (bp.UPD_TAKEN & (bp.UPD_TARGET != bp.UPD_PRED_TARGET)));

  assign bp.PRED_HIT    = pred_hit_s;
  assign bp.PRED_TAKEN  = pred_taken_s;
  assign bp.PRED_TARGET = pred_taken_s ? target_r[if_idx_s] : (bp.IF_PC + 32'd4);
  assign bp.MISPREDICT  = mispredict_s;
  assign bp.REDIRECT_PC = bp.UPD_TAKEN ? bp.UPD_TARGET : (bp.UPD_PC + 32'd4);
  assign bp.LOOKUP_CNT  = lookup_cnt_r;
  assign bp.MISPRED_CNT = mispred_cnt_r;

  // Table training and statistics; reset wins over stall and training
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]   <= 1'b0;
        tag_r[i]     <= {TAGW{1'b0}};
        target_r[i]  <= 32'd0;
        is_cond_r[i] <= 1'b0;
        ctr_r[i]     <= CTR_MIN;
      end
      lookup_cnt_r  <= {STAT_W{1'b0}};
      mispred_cnt_r <= {STAT_W{1'b0}};
    end else if (!bp.STALL) begin
      if (pred_hit_s)   lookup_cnt_r  <= lookup_cnt_r + STAT_W'(1'b1);
      if (mispredict_s) mispred_cnt_r <= mispred_cnt_r + STAT_W'(1'b1);
      if (bp.UPD_VALID) begin
        if (upd_hit_s) begin
          if (bp.UPD_IS_COND) ctr_r[upd_idx_s] <= ctr_step(ctr_r[upd_idx_s], bp.UPD_TAKEN);
          if (bp.UPD_TAKEN)   target_r[upd_idx_s] <= bp.UPD_TARGET;
          is_cond_r[upd_idx_s] <= bp.UPD_IS_COND;
        end else if (bp.UPD_TAKEN) begin
          // Only taken branches earn an entry; start weakly taken
          valid_r[upd_idx_s]   <= 1'b1;
          tag_r[upd_idx_s]     <= upd_tag_s;
          target_r[upd_idx_s]  <= bp.UPD_TARGET;
          is_cond_r[upd_idx_s] <= bp.UPD_IS_COND;
          ctr_r[upd_idx_s]     <= CTR_WEAK;
        end
      end
    end
  end
endmodule

// File: tb/tb_otter_branch_predictor.sv
// Directed bench for otter_branch_predictor (ENTRIES=16, COUNTER_BITS=2).
module tb_otter_branch_predictor;
  logic clk;
  logic rst;
  int   checks;
  int   passes;

  otter_branch_predictor_if bp_if ();

  otter_branch_predictor dut (
    .CLK (clk),
    .RST (rst),
    .bp  (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bp_if.STALL           = 1'b0;
    bp_if.IF_PC           = 32'h3C;
    bp_if.UPD_VALID       = 1'b0;
    bp_if.UPD_PC          = 32'h0;
    bp_if.UPD_IS_COND     = 1'b0;
    bp_if.UPD_TAKEN       = 1'b0;
    bp_if.UPD_TARGET      = 32'h0;
    bp_if.UPD_PRED_TAKEN  = 1'b0;
    bp_if.UPD_PRED_TARGET = 32'h0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic is_cond, input logic taken,
                     input logic [31:0] tgt, input logic p_taken, input logic [31:0] p_tgt);
    bp_if.UPD_VALID       = 1'b1;
    bp_if.UPD_PC          = pc;
    bp_if.UPD_IS_COND     = is_cond;
    bp_if.UPD_TAKEN       = taken;
    bp_if.UPD_TARGET      = tgt;
    bp_if.UPD_PRED_TAKEN  = p_taken;
    bp_if.UPD_PRED_TARGET = p_tgt;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int pc = 0; pc <= 'h3C; pc += 4) begin
      bp_if.IF_PC = 32'(pc);
      #1;
      checks++;
      if (bp_if.PRED_HIT !== 1'b0 || bp_if.PRED_TAKEN !== 1'b0 || bp_if.PRED_TARGET !== 32'(pc + 4))
        $display("FAIL reset_sweep pc=%h got hit=%b taken=%b tgt=%h want 0 0 %h",
                 pc, bp_if.PRED_HIT, bp_if.PRED_TAKEN, bp_if.PRED_TARGET, pc + 4);
      else passes++;
    end
    bp_if.IF_PC = 32'h3C;
    checks++;
    if (bp_if.LOOKUP_CNT !== 32'd0 || bp_if.MISPRED_CNT !== 32'd0 || bp_if.MISPREDICT !== 1'b0)
      $display("FAIL reset_counters got lk=%0d mp=%0d mis=%b want 0 0 0",
               bp_if.LOOKUP_CNT, bp_if.MISPRED_CNT, bp_if.MISPREDICT);
    else passes++;
  endtask

  task automatic test_train_taken();
    upd(32'h40, 1'b1, 1'b1, 32'h10, 1'b0, 32'h44);
    #1;
    checks++;
    if (bp_if.MISPREDICT !== 1'b1 || bp_if.REDIRECT_PC !== 32'h10)
      $display("FAIL train_mispredict got mis=%b redir=%h want 1 00000010",
               bp_if.MISPREDICT, bp_if.REDIRECT_PC);
    else passes++;
    tick();
    idle();
    bp_if.IF_PC = 32'h40;
    #1;
    checks++;
    if (bp_if.PRED_HIT !== 1'b1 || bp_if.PRED_TAKEN !== 1'b1 || bp_if.PRED_TARGET !== 32'h10)
      $display("FAIL train_lookup got hit=%b taken=%b tgt=%h want 1 1 00000010",
               bp_if.PRED_HIT, bp_if.PRED_TAKEN, bp_if.PRED_TARGET);
    else passes++;
    tick();
    checks++;
    if (bp_if.LOOKUP_CNT !== 32'd1 || bp_if.MISPRED_CNT !== 32'd1)
      $display("FAIL train_counters got lk=%0d mp=%0d want 1 1", bp_if.LOOKUP_CNT, bp_if.MISPRED_CNT);
    else passes++;
    bp_if.IF_PC = 32'h3C;
  endtask

  task automatic test_ctr_saturate();
    upd(32'h40, 1'b1, 1'b0, 32'h10, 1'b1, 32'h10);
    tick();
    bp_if.IF_PC = 32'h40;
    #1;
    checks++;
    if (bp_if.PRED_HIT !== 1'b1 || bp_if.PRED_TAKEN !== 1'b0)
      $display("FAIL ctr_weak_nt got hit=%b taken=%b want 1 0", bp_if.PRED_HIT, bp_if.PRED_TAKEN);
    else passes++;
    bp_if.IF_PC = 32'h3C;
    upd(32'h40, 1'b1, 1'b0, 32'h10, 1'b0, 32'h44);
    #1;
    checks++;
    if (bp_if.MISPREDICT !== 1'b0 || bp_if.REDIRECT_PC !== 32'h44)
      $display("FAIL ctr_correct_pred got mis=%b redir=%h want 0 00000044",
               bp_if.MISPREDICT, bp_if.REDIRECT_PC);
    else passes++;
    tick();
    tick();
    idle();
    bp_if.IF_PC = 32'h40;
    #1;
    checks++;
    if (bp_if.PRED_HIT !== 1'b1 || bp_if.PRED_TAKEN !== 1'b0 || bp_if.PRED_TARGET !== 32'h44)
      $display("FAIL ctr_saturate got hit=%b taken=%b tgt=%h want 1 0 00000044",
               bp_if.PRED_HIT, bp_if.PRED_TAKEN, bp_if.PRED_TARGET);
    else passes++;
    bp_if.IF_PC = 32'h3C;
    checks++;
    if (bp_if.MISPRED_CNT !== 32'd2)
      $display("FAIL ctr_mispred_cnt got %0d want 2", bp_if.MISPRED_CNT);
    else passes++;
  endtask

  task automatic test_evict();
    upd(32'h08, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0C);
    tick();
    bp_if.IF_PC = 32'h08;
    #1;
    checks++;
    if (bp_if.PRED_TAKEN !== 1'b1 || bp_if.PRED_TARGET !== 32'h100)
      $display("FAIL evict_first got taken=%b tgt=%h want 1 00000100", bp_if.PRED_TAKEN, bp_if.PRED_TARGET);
    else passes++;
    bp_if.IF_PC = 32'h3C;
    upd(32'h48, 1'b0, 1'b1, 32'h200, 1'b0, 32'h4C);
    tick();
    idle();
    bp_if.IF_PC = 32'h08;
    #1;
    checks++;
    if (bp_if.PRED_HIT !== 1'b0 || bp_if.PRED_TARGET !== 32'h0C)
      $display("FAIL evict_old got hit=%b tgt=%h want 0 0000000c", bp_if.PRED_HIT, bp_if.PRED_TARGET);
    else passes++;
    bp_if.IF_PC = 32'h48;
    #1;
    checks++;
    if (bp_if.PRED_HIT !== 1'b1 || bp_if.PRED_TAKEN !== 1'b1 || bp_if.PRED_TARGET !== 32'h200)
      $display("FAIL evict_new got hit=%b taken=%b tgt=%h want 1 1 00000200",
               bp_if.PRED_HIT, bp_if.PRED_TAKEN, bp_if.PRED_TARGET);
    else passes++;
    bp_if.IF_PC = 32'h3C;
  endtask

  task automatic test_stall();
    bp_if.STALL = 1'b1;
    bp_if.IF_PC = 32'h48;
    upd(32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 32'h44);
    #1;
    checks++;
    if (bp_if.MISPREDICT !== 1'b1 || bp_if.REDIRECT_PC !== 32'h80)
      $display("FAIL stall_mispredict got mis=%b redir=%h want 1 00000080",
               bp_if.MISPREDICT, bp_if.REDIRECT_PC);
    else passes++;
    tick();
    tick();
    idle();
    checks++;
    if (bp_if.LOOKUP_CNT !== 32'd1 || bp_if.MISPRED_CNT !== 32'd4)
      $display("FAIL stall_counters got lk=%0d mp=%0d want 1 4", bp_if.LOOKUP_CNT, bp_if.MISPRED_CNT);
    else passes++;
    bp_if.IF_PC = 32'h40;
    #1;
    checks++;
    if (bp_if.PRED_TAKEN !== 1'b0 || bp_if.PRED_TARGET !== 32'h44)
      $display("FAIL stall_table got taken=%b tgt=%h want 0 00000044", bp_if.PRED_TAKEN, bp_if.PRED_TARGET);
    else passes++;
    bp_if.IF_PC = 32'h3C;
  endtask

  task automatic test_wrap();
    bp_if.IF_PC = 32'hFFFF_FFFC;
    upd(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    checks++;
    if (bp_if.PRED_HIT !== 1'b0 || bp_if.PRED_TARGET !== 32'h0 || bp_if.REDIRECT_PC !== 32'h0)
      $display("FAIL pc_wrap got hit=%b tgt=%h redir=%h want 0 00000000 00000000",
               bp_if.PRED_HIT, bp_if.PRED_TARGET, bp_if.REDIRECT_PC);
    else passes++;
    idle();
  endtask

  task automatic test_back_to_back();
    bp_if.IF_PC = 32'h48;
    upd(32'h48, 1'b0, 1'b1, 32'h300, 1'b1, 32'h200);
    #1;
    checks++;
    if (bp_if.PRED_TARGET !== 32'h200 || bp_if.MISPREDICT !== 1'b1)
      $display("FAIL same_cycle_old got tgt=%h mis=%b want 00000200 1", bp_if.PRED_TARGET, bp_if.MISPREDICT);
    else passes++;
    tick();
    bp_if.UPD_VALID = 1'b0;
    #1;
    checks++;
    if (bp_if.PRED_TARGET !== 32'h300 || bp_if.PRED_TAKEN !== 1'b1)
      $display("FAIL same_cycle_new got tgt=%h taken=%b want 00000300 1", bp_if.PRED_TARGET, bp_if.PRED_TAKEN);
    else passes++;
    checks++;
    if (bp_if.LOOKUP_CNT !== 32'd2 || bp_if.MISPRED_CNT !== 32'd5)
      $display("FAIL same_cycle_counters got lk=%0d mp=%0d want 2 5", bp_if.LOOKUP_CNT, bp_if.MISPRED_CNT);
    else passes++;
  endtask

  task automatic test_mid_reset();
    bp_if.IF_PC = 32'h48;
    bp_if.STALL = 1'b1;
    upd(32'h40, 1'b1, 1'b1, 32'h500, 1'b0, 32'h44);
    rst = 1'b1;
    #1;
    checks++;
    if (bp_if.PRED_HIT !== 1'b0 || bp_if.PRED_TARGET !== 32'h4C)
      $display("FAIL mid_reset_during got hit=%b tgt=%h want 0 0000004c", bp_if.PRED_HIT, bp_if.PRED_TARGET);
    else passes++;
    tick();
    rst = 1'b0;
    idle();
    bp_if.IF_PC = 32'h48;
    #1;
    checks++;
    if (bp_if.PRED_HIT !== 1'b0 || bp_if.PRED_TAKEN !== 1'b0 || bp_if.PRED_TARGET !== 32'h4C ||
        bp_if.MISPREDICT !== 1'b0 || bp_if.LOOKUP_CNT !== 32'd0 || bp_if.MISPRED_CNT !== 32'd0)
      $display("FAIL mid_reset_after got hit=%b taken=%b tgt=%h mis=%b lk=%0d mp=%0d want 0 0 0000004c 0 0 0",
               bp_if.PRED_HIT, bp_if.PRED_TAKEN, bp_if.PRED_TARGET, bp_if.MISPREDICT,
               bp_if.LOOKUP_CNT, bp_if.MISPRED_CNT);
    else passes++;
    bp_if.IF_PC = 32'h40;
    #1;
    checks++;
    if (bp_if.PRED_HIT !== 1'b0 || bp_if.PRED_TARGET !== 32'h44)
      $display("FAIL mid_reset_entry got hit=%b tgt=%h want 0 00000044", bp_if.PRED_HIT, bp_if.PRED_TARGET);
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst    = 1'b1;
    idle();
    test_reset();
    test_train_taken();
    test_ctr_saturate();
    test_evict();
    test_stall();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
